// File: rtl/encoder_pkg.sv
// Shared sizing, index type and the all-zero index for the 8-to-3 encoder.
package encoder_pkg;

    localparam int NUM_IN = 8;
    localparam int IDX_W  = 3;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t IDX_ZERO = '0;

    // Index reported when no request line is active (same code as D0).
    function automatic idx_t idx_zero();
        return IDX_ZERO;
    endfunction

endpackage : encoder_pkg

// File: rtl/encoder_core.sv
// Combinational priority encoder: highest active request wins, plus
// any-active and more-than-one-active qualifiers.
module encoder_core
    import encoder_pkg::*;
(
    input  logic [NUM_IN-1:0] d,
    output idx_t              idx,
    output logic              any,
    output logic              multi
);

    localparam logic [NUM_IN-1:0] ONE = {{(NUM_IN-1){1'b0}}, 1'b1};

    // Scan upward so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx = idx_zero();
        for (int k = 0; k < NUM_IN; k++) begin
            if (d[k]) begin
                idx = IDX_W'(k);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    always_comb begin
        any   = |d;
        multi = |(d & (d - ONE));
    end

endmodule : encoder_core

// File: rtl/encoder_8x3.sv
// Registered 8-to-3 priority encoder with valid and multi-hot flags.
// Outputs come straight from flops; one cycle of latency.
module encoder_8x3
    import encoder_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic D4,
    input  logic D5,
    input  logic D6,
    input  logic D7,
    output logic A0,
    output logic A1,
    output logic A2,
    output logic valid,
    output logic multi_hot
);

    logic [NUM_IN-1:0] d_vec;
    idx_t              idx_c;
    logic              any_c;
    logic              multi_c;

    idx_t idx_d,   idx_q;
    logic valid_d, valid_q;
    logic multi_d, multi_q;

    assign d_vec = {D7, D6, D5, D4, D3, D2, D1, D0};

    encoder_core u_core (
        .d     (d_vec),
        .idx   (idx_c),
        .any   (any_c),
        .multi (multi_c)
    );

    // Next-state for the output register is the core result of this cycle.
    always_comb begin
        idx_d   = idx_c;
        valid_d = any_c;
        multi_d = multi_c;
    end

    // Output register; reset clears everything without needing a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= idx_zero();
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign A0        = idx_q[0];
    assign A1        = idx_q[1];
    assign A2        = idx_q[2];
    assign valid     = valid_q;
    assign multi_hot = multi_q;

endmodule : encoder_8x3

// File: tb/tb_encoder_8x3.sv
// Directed bench for encoder_8x3 with a queue of expected outputs.
module tb_encoder_8x3;

    typedef struct packed {
        logic [2:0] idx;
        logic       vld;
        logic       mh;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] d_vec;
    logic       A0, A1, A2, valid, multi_hot;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    encoder_8x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .D0        (d_vec[0]),
        .D1        (d_vec[1]),
        .D2        (d_vec[2]),
        .D3        (d_vec[3]),
        .D4        (d_vec[4]),
        .D5        (d_vec[5]),
        .D6        (d_vec[6]),
        .D7        (d_vec[7]),
        .A0        (A0),
        .A1        (A1),
        .A2        (A2),
        .valid     (valid),
        .multi_hot (multi_hot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: highest set bit, plus a bit count for the flags.
    function automatic exp_t model(input logic [7:0] v);
        exp_t e;
        int   n;
        e.idx = 3'd0;
        n = 0;
        for (int k = 7; k >= 0; k--) begin
            if (v[k]) begin
                if (n == 0) e.idx = 3'(k);
                n++;
            end
        end
        e.vld = (n > 0);
        e.mh  = (n > 1);
        return e;
    endfunction

    task automatic check_vec(input string tag, input exp_t e);
        exp_t obs;
        obs = {A2, A1, A0, valid, multi_hot};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed A=%b valid=%b multi_hot=%b, expected A=%b valid=%b multi_hot=%b",
                   tag, obs.idx, obs.vld, obs.mh, e.idx, e.vld, e.mh);
        end
    endtask

    // Apply inputs between edges and record what the next edge must produce.
    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        d_vec = v;
        q.push_back(model(v));
    endtask

    // Just after the next rising edge, compare against the oldest expectation.
    task automatic collect(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, observed A=%b%b%b", tag, A2, A1, A0);
        end else begin
            e = q.pop_front();
            check_vec(tag, e);
        end
    endtask

    initial begin
        string tag;
        logic [7:0] r;

        // Async reset with random inputs, before any clock edge.
        d_vec = 8'($urandom);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_vec("reset_async", '0);

        // All-zero input, release reset.
        drive(8'h00);
        rst_n = 1'b1;
        collect("all_zero");

        // One-hot sweep.
        for (int k = 0; k < 8; k++) begin
            drive(8'(1 << k));
            tag = $sformatf("onehot_d%0d", k);
            collect(tag);
        end

        // Priority and multi-hot.
        drive(8'h28); collect("d3_d5");
        drive(8'hFF); collect("all_high");
        drive(8'h03); collect("d0_d1");
        drive(8'h00); collect("back_to_zero");
        for (int i = 0; i < 4; i++) begin
            r = 8'($urandom);
            drive(r);
            tag = $sformatf("random_%02h", r);
            collect(tag);
        end

        // Reset mid-operation with D6 held.
        drive(8'h40); collect("d6_before_reset");
        #2 rst_n = 1'b0;
        #1 check_vec("mid_reset_immediate", '0);
        @(posedge clk);
        #1 check_vec("reset_hold_across_edge", '0);
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(model(8'h40));
        collect("after_release_d6");

        // Latency: change inputs just after an edge.
        drive(8'h10); collect("latency_setup_d4");
        d_vec = 8'h81;
        q.push_back(model(8'h81));
        #2 check_vec("latency_hold", model(8'h10));
        collect("latency_update");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_encoder_8x3
